// File: rtl/nx_fifo_rd_pkg.sv
// Shared types for the FIFO read stage.
// Holds the buffer-state encoding and the occupancy width.
package nx_fifo_rd_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/nx_fifo_rd_stage.sv
// Two-entry registered read stage behind an nx_fifo.
// Pops the FIFO whenever a slot is free; ren never depends on out_ready.
module nx_fifo_rd_stage
  import nx_fifo_rd_pkg::*;
#(
  parameter int WIDTH      = 132,
  parameter bit DATA_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_underflow,
  output logic             fifo_ren,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy,
  output logic             err
);

  rd_state_e        state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             err_q, err_d;
  logic             push, pop;
  logic             has_room;

  assign has_room  = (state_q == EMPTY) || (state_q == ONE);
  assign fifo_ren  = rst_n & ~clear & ~fifo_empty & has_room;
  assign out_valid = (state_q == ONE) || (state_q == TWO);
  assign out_data  = head_q;
  assign occupancy = OCC_W'(state_q);
  assign err       = err_q;

  assign push = fifo_ren;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    err_d   = err_q | fifo_underflow;
    if (clear) begin
      state_d = EMPTY;
      head_d  = '0;
      tail_d  = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_d  = fifo_rdata;
          end
        end
        ONE: begin
          unique case (1'b1)
            push && !pop: begin
              state_d = TWO;
              tail_d  = fifo_rdata;
            end
            !push && pop: begin
              state_d = EMPTY;
              head_d  = '0;
            end
            push && pop: begin
              head_d = fifo_rdata;
            end
            default: ;
          endcase
        end
        TWO: begin
          // head is always the oldest word, so a pop shifts tail forward
          if (pop) begin
            state_d = ONE;
            head_d  = tail_q;
            tail_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = '0;
          tail_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      err_q   <= err_d;
    end
  end

  // head always resets so out_data reads 0 when empty
  always_ff @(posedge clk) begin
    if (DATA_RESET && !rst_n) begin
      tail_q <= '0;
    end else begin
      tail_q <= tail_d;
    end
  end

endmodule

// File: doc/nx_fifo_rd_stage.md
NX_FIFO_RD_STAGE -- requirements
Module: nx_fifo_rd_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 132, giving the data word width.
REQ-002 The block SHALL have parameter DATA_RESET, default 1; when 1, buffer data registers reset to 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port clear, input, 1 bit: synchronous flush of the buffered words and the error flag.
REQ-006 The block SHALL have port fifo_empty, input, 1 bit: empty flag of the upstream nx_fifo.
REQ-007 The block SHALL have port fifo_rdata, input, WIDTH bits: head word of the upstream FIFO, combinationally valid while fifo_empty=0.
REQ-008 The block SHALL have port fifo_underflow, input, 1 bit: upstream FIFO underflow pulse.
REQ-009 The block SHALL have port fifo_ren, output, 1 bit: pop strobe to the upstream FIFO.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts out_data when out_valid=1 and out_ready=1.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: head buffered word, driven from a register.
REQ-013 The block SHALL have port occupancy, output, 2 bits: number of buffered words, 0..2.
REQ-014 The block SHALL have port err, output, 1 bit: sticky error flag.

Function
REQ-015 The block SHALL hold a 2-entry in-order buffer with states EMPTY (0 words), ONE (1 word) and TWO (2 words); occupancy equals the state count.
REQ-016 fifo_ren SHALL be asserted exactly when fifo_empty=0, clear=0, rst_n=1 and the state is not TWO.
REQ-017 fifo_ren SHALL have no combinational dependence on out_ready.
REQ-018 A push SHALL occur when fifo_ren=1; the block captures fifo_rdata in the same cycle.
REQ-019 A pop SHALL occur when out_valid=1 and out_ready=1.
REQ-020 Latency: a word present at the FIFO head in cycle N with the stage in EMPTY SHALL appear on out_data with out_valid=1 in cycle N+1.
REQ-021 Transitions without clear SHALL be:
  - EMPTY: push->ONE.
  - ONE: push only->TWO; pop only->EMPTY; push and pop->ONE, with the new word becoming the head.
  - TWO: pop->ONE, with the second word moving to the head. No push can occur in TWO.
REQ-022 Words SHALL leave the block in the order they were popped from the FIFO; none is dropped or duplicated.
REQ-023 out_valid SHALL be 1 exactly when the state is ONE or TWO.
REQ-024 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 When the state is EMPTY, out_data SHALL equal 0.
REQ-026 With the FIFO non-empty and out_ready held at 1, the block SHALL sustain one word per cycle.
REQ-027 clear=1 SHALL force the state to EMPTY on the next edge and discard any concurrent push or pop.
REQ-028 clear=1 SHALL clear err on the next edge and hold fifo_ren=0 during that cycle.
REQ-029 err SHALL be set on any cycle with fifo_underflow=1 and clear=0, and SHALL hold until clear or reset.
REQ-030 Pointer and count arithmetic SHALL be exact within 2 bits; a push in TWO SHALL be impossible by construction.

Reset
REQ-031 rst_n=0 sampled at a clock edge SHALL set state EMPTY, out_valid=0, occupancy=0, err=0, fifo_ren=0 (combinationally while rst_n=0), and out_data=0.
REQ-032 With DATA_RESET=1, both buffer entries SHALL reset to 0.
REQ-033 Reset asserted mid-transfer SHALL discard buffered words; there SHALL be no pop acknowledgment of discarded words.

Structure
REQ-034 The state enum (EMPTY/ONE/TWO) SHALL be a typedef in shared package nx_fifo_rd_pkg, together with the occupancy width constant.
REQ-035 The block SHALL instantiate no sub-module; the two entries, state register and steering are inline.

Verification
REQ-036 Reset then idle: out_valid=0, out_data=0, occupancy=0 and fifo_ren=0 with fifo_empty=1.
REQ-037 FIFO holds 0xA, 0xB, 0xC; out_ready=1 continuously -> fifo_ren high for 3 cycles, then out_data 0xA, 0xB, 0xC on consecutive cycles starting 1 cycle after the first ren.
REQ-038 FIFO holds 0x1..0x4; out_ready=0 -> exactly 2 pops, occupancy=2, fifo_ren=0, out_data=0x1 held.
   - Then out_ready=1 -> outputs 0x1, 0x2, 0x3, 0x4 in order.
REQ-039 State ONE with a simultaneous push and pop -> occupancy stays 1 and out_data shows the new word next cycle.
REQ-040 State TWO, then clear=1 for one cycle -> next cycle occupancy=0, out_valid=0 and err=0; no fifo_ren during the clear cycle.
REQ-041 fifo_underflow pulsed once -> err=1 and held for 10+ cycles; a clear pulse -> err=0.
